// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tile_renderer
// Description : Per-frame snapshot of the 8x8 tile map; maps VGA coordinates
//               to sprite-ROM addresses and returns RGB with 3-cycle latency.
// Revision    : 1.0
// ============================================================================
module tile_renderer #(
    parameter int          X0       = 192,
    parameter int          Y0       = 112,
    parameter logic [11:0] BG_COLOR = 12'h222,
    parameter int          DARK_MIN = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] Row1,
    input  logic [39:0] Row2,
    input  logic [39:0] Row3,
    input  logic [39:0] Row4,
    input  logic [39:0] Row5,
    input  logic [39:0] Row6,
    input  logic [39:0] Row7,
    input  logic [39:0] Row8,
    input  logic        frame_tick,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] pixel_rgb,
    output logic        pixel_valid
);

    logic [39:0] w_rows [8];
    logic [4:0]  shadow_q [64];

    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_in_grid;
    logic [4:0]  w_idx;
    logic        w_dark;
    logic [12:0] rom_addr_d;

    logic [12:0] rom_addr_q;
    logic        valid1_q, grid1_q, dark1_q;
    logic        valid2_q, grid2_q, dark2_q;
    logic [11:0] rgb_d, rgb_q;
    logic        pv_d, pv_q;

    assign w_rows[0] = Row1;
    assign w_rows[1] = Row2;
    assign w_rows[2] = Row3;
    assign w_rows[3] = Row4;
    assign w_rows[4] = Row5;
    assign w_rows[5] = Row6;
    assign w_rows[6] = Row7;
    assign w_rows[7] = Row8;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                shadow_q[i] <= 5'd31;
            end
        end else if (frame_tick) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    shadow_q[r*8 + c] <= w_rows[r][39 - 5*c -: 5];
                end
            end
        end
    end

    // Coordinates are decoded at capture so the ROM read fits inside the
    // 3-cycle budget; the lower bound check keeps wrapped dx/dy out of the grid.
    assign w_dx      = h_cnt - 10'(X0);
    assign w_dy      = v_cnt - 10'(Y0);
    assign w_in_grid = (h_cnt >= 10'(X0)) && (w_dx[9:8] == 2'b00) &&
                       (v_cnt >= 10'(Y0)) && (w_dy[9:8] == 2'b00);
    assign w_idx     = shadow_q[{w_dy[7:5], w_dx[7:5]}];
    assign w_dark    = (w_idx >= 5'(DARK_MIN));

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (w_in_grid) begin
            rom_addr_d = {w_idx, w_dy[4:1], w_dx[4:1]};
        end
    end

    always_comb begin
        rgb_d = 12'h000;
        pv_d  = 1'b0;
        if (valid2_q) begin
            pv_d = 1'b1;
            if (!grid2_q) begin
                rgb_d = BG_COLOR;
            end else if (dark2_q) begin
                rgb_d = 12'h000;
            end else begin
                rgb_d = rom_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr_q <= 13'd0;
            valid1_q   <= 1'b0;
            grid1_q    <= 1'b0;
            dark1_q    <= 1'b0;
            valid2_q   <= 1'b0;
            grid2_q    <= 1'b0;
            dark2_q    <= 1'b0;
            rgb_q      <= 12'h000;
            pv_q       <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            valid1_q   <= valid;
            grid1_q    <= w_in_grid;
            dark1_q    <= w_dark;
            valid2_q   <= valid1_q;
            grid2_q    <= grid1_q;
            dark2_q    <= dark1_q;
            rgb_q      <= rgb_d;
            pv_q       <= pv_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign pixel_rgb   = rgb_q;
    assign pixel_valid = pv_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_renderer
// Description : Directed self-checking bench for tile_renderer.
// Revision    : 1.0
// ============================================================================
module tb_tile_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] Row1, Row2, Row3, Row4, Row5, Row6, Row7, Row8;
    logic        frame_tick;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid;
    logic [12:0] rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [11:0] pixel_rgb;
    logic        pixel_valid;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [39:0] c_ALL_DARK = {8{5'd31}};

    tile_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .Row1        (Row1),
        .Row2        (Row2),
        .Row3        (Row3),
        .Row4        (Row4),
        .Row5        (Row5),
        .Row6        (Row6),
        .Row7        (Row7),
        .Row8        (Row8),
        .frame_tick  (frame_tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_rgb   (pixel_rgb),
        .pixel_valid (pixel_valid)
    );

    always #5 clk = ~clk;

    // Sprite ROM model: one special word, otherwise a scrambled address.
    function automatic logic [11:0] rom_f(input logic [12:0] a);
        if (a == 13'd2560) return 12'hF00;
        return a[11:0] ^ 12'hA5A;
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int h, input int v, input logic val);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = val;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic drain();
        valid = 1'b0;
        step(3);
    endtask

    initial begin
        rst = 1'b0;
        frame_tick = 1'b0;
        {Row1, Row2, Row3, Row4, Row5, Row6, Row7, Row8} = {8{c_ALL_DARK}};
        pix(192, 112, 1'b1);

        // Reset held with an active in-grid pixel
        #1;
        check("rst_rgb", 16'(pixel_rgb), 16'h000);
        check("rst_pv", 16'(pixel_valid), 16'h0);
        check("rst_addr", 16'(rom_addr), 16'd0);
        step(3);
        check("rst_hold_pv", 16'(pixel_valid), 16'h0);
        rst = 1'b1;
        step(1);
        check("post_rst_addr", 16'(rom_addr), 16'd7936);
        step(2);
        check("post_rst_rgb", 16'(pixel_rgb), 16'h000);
        check("post_rst_pv", 16'(pixel_valid), 16'h1);
        drain();

        // Lookup and exact latency
        Row8 = {5'd10, {7{5'd31}}};
        tick();
        pix(192, 336, 1'b1);
        step(1);
        check("lookup_addr", 16'(rom_addr), 16'd2560);
        step(1);
        check("lookup_n2_pv", 16'(pixel_valid), 16'h0);
        step(1);
        check("lookup_rgb", 16'(pixel_rgb), 16'hF00);
        check("lookup_pv", 16'(pixel_valid), 16'h1);
        drain();

        // Bottom edge: v=367 inside, v=368 outside
        pix(192, 367, 1'b1);
        step(1);
        check("v367_addr", 16'(rom_addr), 16'd2800);
        step(2);
        check("v367_rgb", 16'(pixel_rgb), 16'h0AA);
        pix(192, 368, 1'b1);
        step(3);
        check("v368_rgb", 16'(pixel_rgb), 16'h222);
        drain();

        // Sub-tile address
        Row2 = {{3{5'd31}}, 5'd5, {4{5'd31}}};
        tick();
        pix(301, 153, 1'b1);
        step(1);
        check("subtile_addr", 16'(rom_addr), 16'd1350);
        step(2);
        check("subtile_rgb", 16'(pixel_rgb), 16'(rom_f(13'd1350)));
        drain();

        // Dark threshold: 18 is a lookup, 19 is black
        Row3 = {5'd18, 5'd19, {6{5'd31}}};
        tick();
        pix(192, 176, 1'b1);
        step(1);
        check("idx18_addr", 16'(rom_addr), 16'd4608);
        step(2);
        check("idx18_rgb", 16'(pixel_rgb), 16'h85A);
        pix(224, 176, 1'b1);
        step(3);
        check("idx19_rgb", 16'(pixel_rgb), 16'h000);
        check("idx19_pv", 16'(pixel_valid), 16'h1);
        drain();

        // Grid edges with Row1 cell 7 = 12
        Row1 = {{7{5'd31}}, 5'd12};
        tick();
        pix(447, 112, 1'b1);
        step(1);
        check("h447_addr", 16'(rom_addr), 16'd3087);
        step(2);
        check("h447_rgb", 16'(pixel_rgb), 16'h655);
        pix(448, 112, 1'b1);
        step(1);
        check("h448_addr_hold", 16'(rom_addr), 16'd3087);
        step(2);
        check("h448_rgb", 16'(pixel_rgb), 16'h222);
        check("h448_pv", 16'(pixel_valid), 16'h1);
        pix(100, 100, 1'b1);
        step(3);
        check("h100_rgb", 16'(pixel_rgb), 16'h222);
        pix(191, 112, 1'b1);
        step(3);
        check("h191_rgb", 16'(pixel_rgb), 16'h222);
        pix(447, 112, 1'b0);
        step(3);
        check("inval_rgb", 16'(pixel_rgb), 16'h000);
        check("inval_pv", 16'(pixel_valid), 16'h0);

        // Snapshot: row change without a tick is invisible
        Row1 = {5'd7, {6{5'd31}}, 5'd12};
        pix(192, 112, 1'b1);
        step(3);
        check("snap_old_rgb", 16'(pixel_rgb), 16'h000);
        check("snap_old_pv", 16'(pixel_valid), 16'h1);
        tick();
        step(1);
        check("snap_new_addr", 16'(rom_addr), 16'd1792);
        step(2);
        check("snap_new_rgb", 16'(pixel_rgb), 16'hD5A);

        // Asynchronous reset mid-line
        check("pre_arst_pv", 16'(pixel_valid), 16'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pv", 16'(pixel_valid), 16'h0);
        check("arst_rgb", 16'(pixel_rgb), 16'h000);
        check("arst_addr", 16'(rom_addr), 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        check("arst_rel_addr", 16'(rom_addr), 16'd7936);
        step(2);
        check("arst_rel_rgb", 16'(pixel_rgb), 16'h000);
        check("arst_rel_pv", 16'(pixel_valid), 16'h1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Display-side consumer of the 8x8 tile map that the game manager drives on Row1..Row8.
- Each 40-bit row holds eight 5-bit image indices; cell 0 (leftmost) is bits [39:35] and cell 7 is bits [4:0].
- The block snapshots the map once per frame, turns the VGA pixel coordinates into a sprite-ROM address, and returns 12-bit RGB through a fixed 3-cycle pipeline.
- It sits between the game manager, the VGA timing generator and the sprite block ROM.

Parameters:
- X0, 192: left screen column of the tile grid.
- Y0, 112: top screen line of the tile grid.
- BG_COLOR, 12'h222: colour for active pixels outside the grid.
- DARK_MIN, 19: indices >= DARK_MIN render as black with no ROM dependence.

Ports:
- clk  in  1  system clock (pixel clock enable is handled upstream; every cycle is one pixel slot).
- rst  in  1  asynchronous, active-low reset.
- Row1..Row8  in  40 each  tile map rows, Row1 = top grid row.
- frame_tick  in  1  single-cycle pulse, first cycle of vertical blanking.
- h_cnt  in  10  current pixel column.
- v_cnt  in  10  current pixel line.
- valid  in  1  high in the active video region.
- rom_addr  out  13  sprite ROM address, {index[4:0], py[3:0], px[3:0]}.
- rom_data  in  12  sprite ROM data; synchronous read, one cycle after rom_addr.
- pixel_rgb  out  12  pixel colour {R4,G4,B4}.
- pixel_valid  out  1  pixel_rgb corresponds to an active pixel.

Behaviour:
- Reset (rst low, asynchronous):
  - all shadow cells = 5'd31;
  - all pipeline registers cleared;
  - rom_addr = 0, pixel_rgb = 0, pixel_valid = 0.
- Shadow map:
  - 64 x 5-bit registers, loaded from all eight Row inputs at the edge ending a frame_tick cycle.
  - Rendering reads only the shadow, so Row changes without a tick have no visible effect.
  - A tick during active video is legal. Pixels whose stage-1 evaluation falls after the load edge use the new map.
- Stage 0 (edge ending cycle N): register h_cnt, v_cnt, valid.
- Stage 1 (edge ending N+1):
  - dx = h - X0, dy = v - Y0, 10-bit unsigned.
  - in_grid = (h >= X0) && (h < X0+256) && (v >= Y0) && (v < Y0+256).
  - col = dx[7:5], row = dy[7:5], px = dx[4:1], py = dy[4:1]. Each image pixel covers 2x2 screen pixels; a tile is 32x32 screen pixels.
  - idx = shadow[row][col].
  - Register rom_addr = {idx, py, px}. When in_grid = 0, rom_addr holds its previous value.
  - Register the flags valid, in_grid and dark = (idx >= DARK_MIN).
- Stage 2 (ROM cycle): the ROM returns rom_data during N+2. The flags are delayed one more register to stay aligned.
- Stage 3 (edge ending N+2): register the output.
  - valid = 0: pixel_rgb = 0, pixel_valid = 0.
  - valid = 1, in_grid = 0: pixel_rgb = BG_COLOR, pixel_valid = 1.
  - valid = 1, in_grid = 1, dark = 1: pixel_rgb = 12'h000, pixel_valid = 1.
  - Otherwise: pixel_rgb = rom_data, pixel_valid = 1.
- Latency: pixel_rgb/pixel_valid for coordinates sampled in cycle N are valid in cycle N+3, and the pipeline takes one new coordinate per cycle. The timing generator delays its sync outputs by 3 to match.
- Boundaries:
  - h = X0+255 is inside the grid (col 7, px 15); h = X0+256 is outside. The same rule applies to v.
  - h < X0 is outside; no wrap-around from unsigned dx is allowed to select a tile.
  - Indices 0..18 are all ROM lookups.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous). The first valid output after release is 3 cycles after valid coordinates are presented.

Test Plan:
- Reset: hold rst low with valid=1, h=192, v=112 -> pixel_rgb=0, pixel_valid=0, rom_addr=0. After release with no tick, the same pixel renders 12'h000 at N+3 (shadow dark).
- Lookup and latency:
  - Row8 = {5'd10, seven 5'd31}, pulse frame_tick, then present h=192, v=336.
  - Expect rom_addr = 2560 at N+1.
  - Model ROM returns 12'hF00 -> pixel_rgb = 12'hF00, pixel_valid = 1 at exactly N+3.
- Sub-tile address: Row2 cell 3 = 5'd5, tick, h=301, v=153 -> px=6, py=4, rom_addr = 1350.
- Grid edges, Row1 cell 7 = 5'd12:
  - h=447, v=112 -> ROM colour.
  - h=448 -> BG_COLOR 12'h222.
  - h=100, v=100 -> 12'h222.
  - valid=0 -> 0 with pixel_valid = 0.
- Snapshot:
  - Change Row1 cell 0 from 31 to 7 without a tick -> h=192, v=112 stays 12'h000.
  - After frame_tick -> rom_addr = 1792 and the ROM colour is output.
- Asynchronous reset mid-line: drop rst while pixel_valid=1 -> pixel_valid falls without a clock edge. After release, the shadow is all dark and needs a new tick.
